// File: rtl/inst_predecode_queue.sv
// Circular word queue with head-instruction predecode and decoder stage sequencing.
// Latency: pushed word visible the cycle after push; in_ready drops only on full, and there is no push-when-full even while popping.
module inst_predecode_queue #(
    parameter int         WORD_BITS  = 16,
    parameter int         DEPTH      = 4,
    parameter logic [3:0] CC_CALL    = 4'd15,
    parameter int         STAGE_BITS = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [WORD_BITS-1:0]    in_word,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [WORD_BITS-1:0]    out_inst,
    output logic [WORD_BITS-1:0]    out_imm,
    output logic                    out_long,
    output logic [STAGE_BITS-1:0]   out_stages,
    output logic [STAGE_BITS-1:0]   out_stage,
    output logic                    out_pre_stage,
    input  logic                    stage_done,
    output logic                    inst_done,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic                  branch;
        logic                  call;
        logic                  is_long;
        logic [STAGE_BITS-1:0] stages;
    } pdec_t;

    logic [DEPTH-1:0][WORD_BITS-1:0] mem_q, mem_d;
    logic [PW-1:0]                   rd_q, rd_d;
    logic [PW-1:0]                   wr_q, wr_d;
    logic [CW-1:0]                   count_q, count_d;
    logic [STAGE_BITS-1:0]           stage_q, stage_d;

    logic [WORD_BITS-1:0]  head;
    logic [PW-1:0]         rd_nxt1;
    pdec_t                 pdec;
    logic                  head_valid;
    logic                  last_stage;
    logic                  stage_adv;
    logic                  done;
    logic                  push;
    logic [CW-1:0]         pop_n;

    // Predecode of the head word; all fields come from storage, not from in_word.
    always_comb begin
        head    = mem_q[rd_q];
        rd_nxt1 = rd_q + PW'(1);

        pdec         = '0;
        pdec.branch  = (head[15:12] == 4'd0);
        pdec.call    = (pdec.branch && (head[11:8] == CC_CALL)) ||
                       (head[15:6] == 10'b0010000001);
        pdec.is_long = !pdec.branch && (head[5:2] == 4'd0) && head[0];
        pdec.stages  = pdec.call ? STAGE_BITS'(2) : STAGE_BITS'(1);
    end

    always_comb begin
        head_valid = (count_q != '0) && (!pdec.is_long || (count_q >= CW'(2)));
        last_stage = (stage_q == (pdec.stages - STAGE_BITS'(1)));
        done       = head_valid && stage_done && last_stage && !flush;
        stage_adv  = head_valid && stage_done && !last_stage && !flush;
        push       = in_valid && (count_q < DEPTH_C) && !flush;
        pop_n      = '0;
        if (done) begin
            pop_n = pdec.is_long ? CW'(2) : CW'(1);
        end
    end

    // Flush wins over everything; storage contents are left stale since pointers reset.
    always_comb begin
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        stage_d = stage_q;
        if (flush) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
            stage_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = in_word;
                wr_d        = wr_q + PW'(1);
            end
            rd_d    = rd_q + PW'(pop_n);
            count_d = count_q + CW'(push) - pop_n;
            if (done) begin
                stage_d = '0;
            end else if (stage_adv) begin
                stage_d = stage_q + STAGE_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            stage_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            stage_q <= stage_d;
        end
    end

    always_comb begin
        in_ready      = (count_q < DEPTH_C);
        out_valid     = head_valid;
        out_inst      = head;
        out_long      = pdec.is_long;
        out_imm       = pdec.is_long ? mem_q[rd_nxt1] : '0;
        out_stages    = pdec.stages;
        out_stage     = stage_q;
        out_pre_stage = head_valid && (pdec.stages == STAGE_BITS'(2)) && (stage_q == '0);
        inst_done     = done;
        count         = count_q;
    end

endmodule

// File: tb/tb_inst_predecode_queue.sv
// Bench for inst_predecode_queue: directed scenarios plus random traffic against a word-queue model.
module tb_inst_predecode_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_word;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_inst;
    logic [15:0] out_imm;
    logic        out_long;
    logic [1:0]  out_stages;
    logic [1:0]  out_stage;
    logic        out_pre_stage;
    logic        stage_done;
    logic        inst_done;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    logic [15:0] mq[$];
    int          mstage = 0;

    inst_predecode_queue #(
        .WORD_BITS(16), .DEPTH(DEPTH), .CC_CALL(4'd15), .STAGE_BITS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_word(in_word), .in_ready(in_ready),
        .out_valid(out_valid), .out_inst(out_inst), .out_imm(out_imm),
        .out_long(out_long), .out_stages(out_stages), .out_stage(out_stage),
        .out_pre_stage(out_pre_stage), .stage_done(stage_done),
        .inst_done(inst_done), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Instruction length and stage count straight from the encoding rules.
    function automatic void classify(input logic [15:0] h, output bit lg, output int st);
        bit br, cl;
        br = (h[15:12] == 4'd0);
        cl = (br && h[11:8] == 4'd15) || (h[15:6] == 10'b0010000001);
        lg = !br && (h[5:2] == 4'd0) && h[0];
        st = cl ? 2 : 1;
    endfunction

    function automatic logic [15:0] gen_word();
        logic [15:0] w;
        w = 16'($urandom);
        case ($urandom_range(0, 3))
            0: ;
            1: w = {4'($urandom_range(1, 15)), w[11:6], 4'b0000, w[1], 1'b1};
            2: w = {4'h0, 4'hF, w[7:0]};
            default: w = {10'b0010000001, w[5:0]};
        endcase
        return w;
    endfunction

    // One clock: drive at posedge+1, compare at posedge+3, advance model at the next posedge.
    task automatic cycle(input logic iv, input logic [15:0] w, input logic sd, input logic fl);
        bit lg, exp_valid, exp_done, do_push;
        int st, cnt;
        in_valid   = iv;
        in_word    = w;
        stage_done = sd;
        flush      = fl;
        #2;
        cnt = mq.size();
        lg  = 1'b0;
        st  = 1;
        if (cnt > 0) classify(mq[0], lg, st);
        exp_valid = (cnt >= 1) && (!lg || cnt >= 2);
        exp_done  = exp_valid && sd && !fl && (mstage == st - 1);
        check_eq("count", count, cnt);
        check_eq("in_ready", in_ready, cnt < DEPTH);
        check_eq("out_valid", out_valid, exp_valid);
        check_eq("out_stage", out_stage, mstage);
        check_eq("inst_done", inst_done, exp_done);
        check_eq("out_pre_stage", out_pre_stage, exp_valid && st == 2 && mstage == 0);
        if (cnt > 0) begin
            check_eq("out_inst", out_inst, mq[0]);
            check_eq("out_long", out_long, lg);
            check_eq("out_stages", out_stages, st);
            if (exp_valid) check_eq("out_imm", out_imm, lg ? mq[1] : 16'h0);
        end
        @(posedge clk);
        do_push = iv && (mq.size() < DEPTH);
        if (fl) begin
            mq.delete();
            mstage = 0;
        end else begin
            if (exp_done) begin
                void'(mq.pop_front());
                if (lg) void'(mq.pop_front());
                mstage = 0;
            end else if (exp_valid && sd) begin
                mstage++;
            end
            if (do_push) mq.push_back(w);
        end
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"}, in_ready, 1);
        check_eq({tag, "_out_valid"}, out_valid, 0);
        check_eq({tag, "_count"}, count, 0);
        check_eq({tag, "_out_stage"}, out_stage, 0);
        check_eq({tag, "_inst_done"}, inst_done, 0);
        check_eq({tag, "_out_imm"}, out_imm, 0);
        check_eq({tag, "_out_long"}, out_long, 0);
        check_eq({tag, "_out_stages"}, out_stages, 1);
        check_eq({tag, "_out_pre_stage"}, out_pre_stage, 0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_word = '0; stage_done = 1'b0;
        #2;
        check_reset_outputs("por");
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;

        // Short ALU op, then a long op whose immediate arrives a cycle later.
        cycle(1, 16'h8123, 0, 0);
        cycle(0, 16'h0000, 1, 0);
        cycle(1, 16'h8041, 0, 0);
        cycle(1, 16'hBEEF, 0, 0);
        cycle(0, 16'h0000, 1, 0);
        // Call-src needing a pre-stage (also long by encoding).
        cycle(1, 16'h2041, 0, 0);
        cycle(1, 16'h1234, 0, 0);
        cycle(0, 16'h0000, 1, 0);
        cycle(0, 16'h0000, 1, 0);
        // Fill, then push while popping from full.
        for (int i = 0; i < DEPTH; i++) cycle(1, 16'(16'h8124 + i), 0, 0);
        cycle(1, 16'h8555, 1, 0);
        cycle(1, 16'h8556, 0, 0);
        for (int i = 0; i < DEPTH; i++) cycle(0, 16'h0000, 1, 0);
        // Long op split across the pointer wrap.
        cycle(1, 16'h8123, 0, 0);
        cycle(1, 16'h8041, 0, 0);
        cycle(1, 16'hCAFE, 0, 0);
        cycle(0, 16'h0000, 1, 0);
        cycle(0, 16'h0000, 1, 0);
        // Flush in the middle of a two-stage branch call.
        cycle(1, 16'h0F12, 0, 0);
        cycle(0, 16'h0000, 1, 0);
        cycle(1, 16'h8123, 1, 1);
        cycle(0, 16'h0000, 0, 0);

        for (int i = 0; i < 2000; i++)
            cycle($urandom_range(0, 3) != 0, gen_word(), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 31) == 0);

        // Asynchronous reset with words queued.
        cycle(1, 16'h8041, 0, 0);
        cycle(1, 16'h0F00, 0, 0);
        cycle(1, 16'h2040, 0, 0);
        in_valid = 1'b0; stage_done = 1'b0; flush = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        mq.delete();
        mstage = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 200; i++)
            cycle($urandom_range(0, 3) != 0, gen_word(), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 31) == 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
